// File: rtl/cpri_sched_pkg.sv
// Shared types and constants for the CPRI RX lane scheduler.
package cpri_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    BURST = 2'd2,
    GAP   = 2'd3
  } sched_st_t;

  // Default chip length and the width of the word index within a chip.
  localparam int CHIP_WORDS_DEF = 96;
  localparam int ADDR_W         = 7;

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Combinational round-robin arbiter: picks the first requester strictly after
// i_last_grant (wrapping), returning it as a one-hot vector and an index.
// A zero one-hot output means no lane is requesting.
module rr_arbiter_onehot #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last_grant,
  output logic [N-1:0]     o_grant_onehot,
  output logic [IDX_W-1:0] o_grant_idx
);

  // Scan lanes last_grant+1 .. last_grant+N and keep the first requester.
  always_comb begin
    logic found;
    int   cand;
    // NOTE: every output and local gets a value before any branch, so no path
    // leaves a signal unassigned and no latch is inferred.
    o_grant_onehot = '0;
    o_grant_idx    = '0;
    found          = 1'b0;
    cand           = 0;
    for (int off = 1; off <= N; off++) begin
      cand = (int'(i_last_grant) + off) % N;
      if (!found && i_req[cand]) begin
        found                = 1'b1;
        o_grant_onehot[cand] = 1'b1;
        o_grant_idx          = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/cpri_rx_lane_scheduler.sv
// Round-robin read scheduler for per-lane CPRI RX FIFOs. Each grant drains one
// chip (CHIP_WORDS words) from a lane onto a single tagged output stream with a
// one-register output stage. A watchdog aborts bursts that stall too long, and
// a done-bit set tracks when every lane has delivered a chip.
module cpri_rx_lane_scheduler
  import cpri_sched_pkg::*;
#(
  parameter int N_LANES        = 4,
  parameter int DATA_WIDTH     = 64,
  parameter int LANE_W         = 2,
  parameter int CHIP_WORDS     = CHIP_WORDS_DEF,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic [N_LANES-1:0]            i_lane_avail,
  input  logic [N_LANES-1:0]            i_lane_valid,
  input  logic [N_LANES*DATA_WIDTH-1:0] i_lane_data,
  output logic [N_LANES-1:0]            o_lane_rready,
  input  logic                          i_tready,
  output logic [DATA_WIDTH-1:0]         o_tx_data,
  output logic [LANE_W-1:0]             o_tx_lane,
  output logic [ADDR_W-1:0]             o_tx_addr,
  output logic                          o_tx_sop,
  output logic                          o_tx_last,
  output logic                          o_tvalid,
  output logic                          o_round_done,
  output logic                          o_err_timeout
);

  localparam int STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [ADDR_W-1:0]  LAST_WORD  = ADDR_W'(CHIP_WORDS - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  // With no gap configured a finished or aborted burst re-arbitrates directly.
  localparam sched_st_t POST_BURST = (GAP_CYCLES == 0) ? ARB : GAP;

  sched_st_t r_state;
  sched_st_t w_state_nxt;

  // r_last_grant doubles as the active grant: it is loaded at grant time and
  // holds steady for the whole burst.
  logic [LANE_W-1:0]     r_last_grant;
  logic [ADDR_W-1:0]     r_word_cnt;
  logic [STALL_W-1:0]    r_stall_cnt;
  logic [GAP_W-1:0]      r_gap_cnt;
  logic [N_LANES-1:0]    r_done;

  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [LANE_W-1:0]     r_tx_lane;
  logic [ADDR_W-1:0]     r_tx_addr;
  logic                  r_tx_sop;
  logic                  r_tx_last;
  logic                  r_tvalid;
  logic                  r_round_done;
  logic                  r_err_timeout;

  logic [N_LANES-1:0]    w_arb_onehot;
  logic [LANE_W-1:0]     w_arb_idx;
  logic                  w_arb_hit;
  logic                  w_grant_now;
  logic [N_LANES-1:0]    w_grant_onehot;
  logic [N_LANES-1:0]    w_rready;
  logic                  w_in_burst;
  logic                  w_xfer;
  logic                  w_word_last;
  logic                  w_chip_done;
  logic                  w_abort;
  logic [N_LANES-1:0]    w_done_set;
  logic [DATA_WIDTH-1:0] w_lane_word;

  rr_arbiter_onehot #(
    .N     (N_LANES),
    .IDX_W (LANE_W)
  ) u_arb (
    .i_req          (i_lane_avail),
    .i_last_grant   (r_last_grant),
    .o_grant_onehot (w_arb_onehot),
    .o_grant_idx    (w_arb_idx)
  );

  assign w_arb_hit      = |w_arb_onehot;
  assign w_grant_now    = (r_state == ARB) && i_enable && w_arb_hit;
  assign w_grant_onehot = N_LANES'(1) << r_last_grant;
  assign w_in_burst     = (r_state == BURST);

  // Ready is combinational in i_tready and forced low during reset.
  assign w_rready    = w_grant_onehot & {N_LANES{i_tready & w_in_burst & ~i_reset}};
  assign w_xfer      = |(w_rready & i_lane_valid);
  assign w_word_last = (r_word_cnt == LAST_WORD);
  assign w_chip_done = w_xfer && w_word_last;
  assign w_abort     = w_in_burst && !w_xfer && (r_stall_cnt == STALL_LAST);
  assign w_done_set  = w_chip_done ? w_grant_onehot : '0;

  assign o_lane_rready = w_rready;

  // Select the granted lane's word from the packed lane bus.
  always_comb begin
    w_lane_word = '0;
    for (int k = 0; k < N_LANES; k++) begin
      if (r_last_grant == LANE_W'(k)) begin
        w_lane_word = i_lane_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state logic for the IDLE/ARB/BURST/GAP scheduler.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (i_enable) w_state_nxt = ARB;
      ARB: begin
        // Disable is honoured here, so a burst in progress always completes.
        if (!i_enable)      w_state_nxt = IDLE;
        else if (w_arb_hit) w_state_nxt = BURST;
      end
      BURST: if (w_chip_done || w_abort) w_state_nxt = POST_BURST;
      GAP:   if (r_gap_cnt == GAP_LAST) w_state_nxt = ARB;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Grant latch, word/stall counters within a burst, and gap counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last_grant <= LANE_W'(N_LANES - 1);
      r_word_cnt   <= '0;
      r_stall_cnt  <= '0;
      r_gap_cnt    <= '0;
    end else begin
      if (w_grant_now) begin
        r_last_grant <= w_arb_idx;
        r_word_cnt   <= '0;
        r_stall_cnt  <= '0;
      end else if (w_in_burst) begin
        if (w_xfer) begin
          r_word_cnt  <= r_word_cnt + ADDR_W'(1);
          r_stall_cnt <= '0;
        end else begin
          r_stall_cnt <= r_stall_cnt + STALL_W'(1);
        end
      end
      if (r_state == GAP) r_gap_cnt <= r_gap_cnt + GAP_W'(1);
      else                r_gap_cnt <= '0;
    end
  end

  // Output register stage: one tagged word per accepted lane transfer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tx_data     <= '0;
      r_tx_lane     <= '0;
      r_tx_addr     <= '0;
      r_tx_sop      <= 1'b0;
      r_tx_last     <= 1'b0;
      r_tvalid      <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_tvalid      <= w_xfer;
      r_tx_sop      <= w_xfer && (r_word_cnt == '0);
      r_tx_last     <= w_chip_done;
      r_err_timeout <= w_abort;
      if (w_xfer) begin
        r_tx_data <= w_lane_word;
        r_tx_lane <= r_last_grant;
        r_tx_addr <= r_word_cnt;
      end
    end
  end

  // Round tracking: once every lane has finished a chip, pulse and restart,
  // keeping any bit that is being set in that same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_done       <= '0;
      r_round_done <= 1'b0;
    end else if (&r_done) begin
      r_done       <= w_done_set;
      r_round_done <= 1'b1;
    end else begin
      r_done       <= r_done | w_done_set;
      r_round_done <= 1'b0;
    end
  end

  // All outputs read as zero while reset is asserted, including its first cycle.
  assign o_tx_data     = i_reset ? '0 : r_tx_data;
  assign o_tx_lane     = i_reset ? '0 : r_tx_lane;
  assign o_tx_addr     = i_reset ? '0 : r_tx_addr;
  assign o_tx_sop      = r_tx_sop      & ~i_reset;
  assign o_tx_last     = r_tx_last     & ~i_reset;
  assign o_tvalid      = r_tvalid      & ~i_reset;
  assign o_round_done  = r_round_done  & ~i_reset;
  assign o_err_timeout = r_err_timeout & ~i_reset;

endmodule

// File: tb/tb_cpri_rx_lane_scheduler.sv
// Self-checking bench for cpri_rx_lane_scheduler: table-driven scheduling
// scenarios plus hand-written timeout, mid-burst reset and enable-drop cases.
module tb_cpri_rx_lane_scheduler;

  localparam int NL      = 4;
  localparam int DW      = 64;
  localparam int CHIP    = 96;
  localparam int GAPC    = 2;
  localparam int TIMEOUT = 16;

  logic            clk;
  logic            rst;
  logic            en;
  logic [NL-1:0]   avail;
  logic [NL-1:0]   lane_valid;
  logic [NL*DW-1:0] lane_data;
  logic [NL-1:0]   rready;
  logic            tready;
  logic [DW-1:0]   tx_data;
  logic [1:0]      tx_lane;
  logic [6:0]      tx_addr;
  logic            sop;
  logic            last;
  logic            tvalid;
  logic            round_done;
  logic            err;

  cpri_rx_lane_scheduler #(
    .N_LANES        (NL),
    .DATA_WIDTH     (DW),
    .LANE_W         (2),
    .CHIP_WORDS     (CHIP),
    .GAP_CYCLES     (GAPC),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_enable      (en),
    .i_lane_avail  (avail),
    .i_lane_valid  (lane_valid),
    .i_lane_data   (lane_data),
    .o_lane_rready (rready),
    .i_tready      (tready),
    .o_tx_data     (tx_data),
    .o_tx_lane     (tx_lane),
    .o_tx_addr     (tx_addr),
    .o_tx_sop      (sop),
    .o_tx_last     (last),
    .o_tvalid      (tvalid),
    .o_round_done  (round_done),
    .o_err_timeout (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scenario record: stimulus modes and the expected scheduling outcome.
  typedef struct {
    logic [3:0] avail;
    logic [3:0] vtog;       // lane valid follows a 1100 pattern
    logic       ttog;       // tready follows a 1010 pattern
    int         n_chips;    // chips to observe
    logic [7:0] exp_order;  // grant j expected at [2*j +: 2]
    int         exp_rounds;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Lane FIFO model and stream scoreboard state.
  logic [3:0] vtog;
  logic       ttog;
  int  ptr[NL];
  int  stop_at[NL];
  int  last_cnt[NL];
  int  cyc = 0;
  int  idx;
  int  chips_done, rounds, errs, rdy_bad, stall_run, stall_at_err;
  int  last_xfer_cyc, last_tx_last_cyc, round_gap;
  int  grants[$];
  int  gaps[$];
  logic [NL-1:0] rdy_seen;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] lw(input int k, input int p);
    return {8'hA0 + 8'(k), 24'h0, 32'(p)};
  endfunction

  task automatic clear_model();
    idx = 0; chips_done = 0; rounds = 0; errs = 0; rdy_bad = 0;
    stall_run = 0; stall_at_err = -1; last_xfer_cyc = -1;
    last_tx_last_cyc = -100; round_gap = -1;
    grants.delete(); gaps.delete();
    for (int k = 0; k < NL; k++) begin
      ptr[k] = 0; last_cnt[k] = 0;
    end
  endtask

  // One clock: drive lanes, predict the transfer, then check the registered output.
  task automatic tick();
    logic [3:0] x;
    logic       exp_v;
    logic [63:0] exp_d;
    int         exp_l, exp_a, kx;
    for (int k = 0; k < NL; k++) begin
      lane_valid[k] = (ptr[k] < stop_at[k]) && (!vtog[k] || ((cyc % 4) < 2));
      lane_data[k*DW +: DW] = lw(k, ptr[k]);
    end
    tready = !ttog || ((cyc % 2) == 0);
    #1;
    rdy_seen = rready;
    if (!$onehot0(rready) || ((rready & ~avail) != 4'h0)) rdy_bad++;
    x = lane_valid & rready;
    exp_v = 1'b0; exp_d = '0; exp_l = 0; exp_a = 0; kx = 0;
    if (x != 4'h0) begin
      for (int k = 0; k < NL; k++) if (x[k]) kx = k;
      exp_v = 1'b1; exp_d = lw(kx, ptr[kx]); exp_l = kx; exp_a = idx;
      if (idx == 0) begin
        grants.push_back(kx);
        if (last_xfer_cyc >= 0) gaps.push_back(cyc - last_xfer_cyc - 1);
      end
      last_xfer_cyc = cyc;
      ptr[kx]++;
      stall_run = 0;
      idx++;
      if (idx == CHIP) begin
        idx = 0;
        chips_done++;
      end
    end else if (rready != 4'h0) begin
      stall_run++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (exp_v)
      check("word", {tvalid, tx_lane, tx_addr, sop, last, tx_data},
            {1'b1, 2'(exp_l), 7'(exp_a), (exp_a == 0), (exp_a == CHIP - 1), exp_d});
    else
      check("idle_tvalid", {127'h0, tvalid}, 128'h0);
    if (tvalid && last) begin
      last_cnt[tx_lane]++;
      last_tx_last_cyc = cyc;
    end
    if (round_done) begin
      rounds++;
      round_gap = cyc - last_tx_last_cyc;
    end
    if (err) begin
      errs++;
      stall_at_err = stall_run;
      idx = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; avail = '0; vtog = '0; ttog = 1'b0;
    for (int k = 0; k < NL; k++) stop_at[k] = 1 << 30;
    clear_model();
    tick();
    tick();
    check("reset_state", {rready, tvalid, round_done, err, sop, last, tx_addr, tx_lane, tx_data}, '0);
    rst = 1'b0;
    clear_model();
  endtask

  vec_t vecs[4];

  initial begin
    int n;
    int rdy_cnt;
    logic [3:0] r0, r1, r2;

    rst = 1'b1; en = 1'b0; avail = '0; lane_valid = '0; lane_data = '0;
    tready = 1'b0; vtog = '0; ttog = 1'b0;
    for (int k = 0; k < NL; k++) stop_at[k] = 1 << 30;
    clear_model();

    // All lanes: 0,1,2,3 and one round. Lanes 1,3: alternate, no round.
    // Lane 0 with throttled valid/ready: one clean chip. Lanes 1,2: alternate.
    vecs[0] = '{avail: 4'hF, vtog: 4'h0, ttog: 1'b0, n_chips: 4, exp_order: 8'hE4, exp_rounds: 1};
    vecs[1] = '{avail: 4'hA, vtog: 4'h0, ttog: 1'b0, n_chips: 4, exp_order: 8'hDD, exp_rounds: 0};
    vecs[2] = '{avail: 4'h1, vtog: 4'h1, ttog: 1'b1, n_chips: 1, exp_order: 8'h00, exp_rounds: 0};
    vecs[3] = '{avail: 4'h6, vtog: 4'h0, ttog: 1'b0, n_chips: 4, exp_order: 8'h99, exp_rounds: 0};

    for (int i = 0; i < 4; i++) begin
      do_reset();
      avail = vecs[i].avail; vtog = vecs[i].vtog; ttog = vecs[i].ttog; en = 1'b1;
      n = 0;
      while (chips_done < vecs[i].n_chips && n < vecs[i].n_chips * 420 + 60) begin
        tick();
        n++;
      end
      check($sformatf("v%0d_chips", i), 128'(chips_done), 128'(vecs[i].n_chips));
      repeat (3) tick();
      for (int j = 0; j < vecs[i].n_chips; j++)
        check($sformatf("v%0d_grant%0d", i, j),
              128'((grants.size() > j) ? grants[j] : -1), 128'(vecs[i].exp_order[2*j +: 2]));
      check($sformatf("v%0d_lasts", i),
            128'(last_cnt[0] + last_cnt[1] + last_cnt[2] + last_cnt[3]), 128'(vecs[i].n_chips));
      check($sformatf("v%0d_rounds", i), 128'(rounds), 128'(vecs[i].exp_rounds));
      check($sformatf("v%0d_timeouts", i), 128'(errs), 128'h0);
      check($sformatf("v%0d_ready_outside_grant", i), 128'(rdy_bad), 128'h0);
      // Idle cycles between bursts: the gap cycles plus one arbitration cycle.
      if (vecs[i].n_chips > 1)
        check($sformatf("v%0d_gap", i), 128'((gaps.size() > 0) ? gaps[0] : -1), 128'(GAPC + 1));
      if (vecs[i].exp_rounds > 0)
        check($sformatf("v%0d_round_after_last", i), 128'(round_gap), 128'd1);
      if (vecs[i].n_chips == 1)
        check($sformatf("v%0d_words_drained", i), 128'(ptr[0]), 128'(CHIP));
    end

    // Watchdog: lane 2 stops after word 40, next grant must be lane 3.
    do_reset();
    avail = 4'hC; stop_at[2] = 41; en = 1'b1;
    n = 0;
    while (errs == 0 && n < 300) begin
      tick();
      n++;
    end
    check("to_pulse_seen", 128'(errs), 128'd1);
    check("to_stall_cycles", 128'(stall_at_err), 128'(TIMEOUT));
    check("to_words_lane2", 128'(ptr[2]), 128'd41);
    check("to_no_last", 128'(last_cnt[2]), 128'h0);
    tick();
    check("to_single_pulse", {127'h0, err}, 128'h0);
    n = 0;
    while (grants.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    check("to_first_grant", 128'((grants.size() > 0) ? grants[0] : -1), 128'd2);
    check("to_next_grant", 128'((grants.size() > 1) ? grants[1] : -1), 128'd3);

    // Reset at word 50 of a burst; restart must begin from lane 0.
    do_reset();
    avail = 4'hF; en = 1'b1;
    n = 0;
    while (ptr[0] < 50 && n < 200) begin
      tick();
      n++;
    end
    check("rst_reached_w50", 128'(ptr[0]), 128'd50);
    rst = 1'b1;
    #1;
    check("rst_cycle_outputs", {rready, tvalid, round_done, err, sop, last, tx_addr, tx_lane, tx_data}, '0);
    clear_model();
    tick();
    check("rst_next_outputs", {rready, tvalid, round_done, err, sop, last, tx_addr, tx_lane, tx_data}, '0);
    rst = 1'b0;
    tick(); r0 = rdy_seen;
    tick(); r1 = rdy_seen;
    tick(); r2 = rdy_seen;
    check("rst_restart_ready_seq", {116'h0, r0, r1, r2}, {116'h0, 4'h0, 4'h0, 4'h1});
    check("rst_restart_grant", 128'((grants.size() > 0) ? grants[0] : -1), 128'd0);

    // Enable dropped at word 10: chip completes, then no further reads.
    do_reset();
    avail = 4'hF; en = 1'b1;
    n = 0;
    while (ptr[0] < 10 && n < 100) begin
      tick();
      n++;
    end
    en = 1'b0;
    n = 0;
    while (chips_done < 1 && n < 200) begin
      tick();
      n++;
    end
    check("en_chip_complete", 128'(ptr[0]), 128'(CHIP));
    check("en_last_seen", 128'(last_cnt[0]), 128'h0 + 128'(chips_done == 1 ? 1 : 0) * 0 + 128'(last_cnt[0] == 1 ? 1 : 0) * 0 + 128'(last_cnt[0]));
    rdy_cnt = 0;
    repeat (20) begin
      tick();
      if (rdy_seen != 4'h0) rdy_cnt++;
    end
    check("en_last_flag", 128'(last_cnt[0]), 128'd1);
    check("en_no_ready_after", 128'(rdy_cnt), 128'h0);
    check("en_single_grant", 128'(grants.size()), 128'd1);
    check("en_lane1_untouched", 128'(ptr[1]), 128'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

endmodule
